// File: rtl/cdc_sync_filter_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared constants and helpers for the multi-channel synchroniser/filter.
//   CDC_MIN_STAGES : fewest synchroniser flops allowed per channel
//   cdc_cnt_width  : width of the per-channel stability counter
// ---------------------------------------------------------------------------
package cdc_pkg;

   localparam int CDC_MIN_STAGES = 2;

   // The counter only has to reach FILTER_CYCLES-1. The extra headroom from
   // +1 keeps the width at least 1 bit when FILTER_CYCLES is 1.
   function automatic int cdc_cnt_width(input int filter_cycles);
      int w;
      w = $clog2(filter_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cdc_sync_filter_channel.sv
// ---------------------------------------------------------------------------
// cdc_sync_channel
// One channel: synchroniser chain, stability filter, registered edge pulses
// and a sticky edge flag with synchronous clear.
//   sysClk_i    : destination clock, posedge
//   reset_ni    : asynchronous active-low reset
//   async_i     : asynchronous input bit
//   clear_i     : synchronous clear of edge_flag_o
//   sync_o      : filtered, synchronised level
//   rising_o    : one-cycle pulse on an accepted 0->1 change
//   falling_o   : one-cycle pulse on an accepted 1->0 change
//   edge_flag_o : sticky, set by either pulse
// ---------------------------------------------------------------------------
module cdc_sync_channel
   import cdc_pkg::*;
#(
   parameter int STAGES        = 2,
   parameter int FILTER_CYCLES = 1,
   parameter bit RESET_VAL     = 1'b0
) (
   input  logic sysClk_i,
   input  logic reset_ni,
   input  logic async_i,
   input  logic clear_i,
   output logic sync_o,
   output logic rising_o,
   output logic falling_o,
   output logic edge_flag_o
);

   localparam int               CNT_W    = cdc_cnt_width(FILTER_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              raw;
   logic              state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              flag_q, flag_d;

   // Pure shift: nothing but wiring between the metastability flops.
   assign chain_d = {chain_q[STAGES-2:0], async_i};
   assign raw     = chain_q[STAGES-1];

   always_ff @(posedge sysClk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         chain_q <= {STAGES{RESET_VAL}};
      end else begin
         chain_q <= chain_d;
      end
   end

   // cnt tracks how many consecutive edges raw has disagreed with state.
   // Any agreement restarts it; reaching FILTER_CYCLES-1 with a further
   // disagreement accepts the new level, so cnt never wraps.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (raw == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         state_d = raw;
         cnt_d   = '0;
         rise_d  = raw;
         fall_d  = ~raw;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end

      // A coincident edge outranks a clear so no event is ever lost.
      flag_d = flag_q;
      if (clear_i) begin
         flag_d = 1'b0;
      end
      if (rise_d || fall_d) begin
         flag_d = 1'b1;
      end
   end

   always_ff @(posedge sysClk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= RESET_VAL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         flag_q  <= flag_d;
      end
   end

   assign sync_o      = state_q;
   assign rising_o    = rise_q;
   assign falling_o   = fall_q;
   assign edge_flag_o = flag_q;

endmodule

// File: rtl/cdc_sync_filter.sv
// ---------------------------------------------------------------------------
// cdc_sync_filter
// WIDTH independent asynchronous bits brought into the sysClk_i domain, each
// with its own synchroniser, optional debounce and edge reporting. Channels
// are not skew-matched: do not use this to carry a coherent multi-bit bus.
//   sysClk_i    : destination clock, posedge
//   reset_ni    : asynchronous active-low reset
//   async_i     : [WIDTH] asynchronous inputs
//   clear_i     : [WIDTH] synchronous clears of edge_flag_o
//   sync_o      : [WIDTH] filtered, synchronised levels
//   rising_o    : [WIDTH] one-cycle rising pulses
//   falling_o   : [WIDTH] one-cycle falling pulses
//   edge_flag_o : [WIDTH] sticky edge flags
// ---------------------------------------------------------------------------
module cdc_sync_filter
   import cdc_pkg::*;
#(
   parameter int WIDTH         = 1,
   parameter int STAGES        = 2,
   parameter int FILTER_CYCLES = 1,
   parameter bit RESET_VAL     = 1'b0
) (
   input  logic             sysClk_i,
   input  logic             reset_ni,
   input  logic [WIDTH-1:0] async_i,
   input  logic [WIDTH-1:0] clear_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] rising_o,
   output logic [WIDTH-1:0] falling_o,
   output logic [WIDTH-1:0] edge_flag_o
);

   if (WIDTH < 1) begin : g_bad_width
      $error("cdc_sync_filter: WIDTH must be at least 1");
   end
   if (STAGES < CDC_MIN_STAGES) begin : g_bad_stages
      $error("cdc_sync_filter: STAGES must be at least %0d", CDC_MIN_STAGES);
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("cdc_sync_filter: FILTER_CYCLES must be at least 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      cdc_sync_channel #(
         .STAGES        (STAGES),
         .FILTER_CYCLES (FILTER_CYCLES),
         .RESET_VAL     (RESET_VAL)
      ) u_ch (
         .sysClk_i    (sysClk_i),
         .reset_ni    (reset_ni),
         .async_i     (async_i[i]),
         .clear_i     (clear_i[i]),
         .sync_o      (sync_o[i]),
         .rising_o    (rising_o[i]),
         .falling_o   (falling_o[i]),
         .edge_flag_o (edge_flag_o[i])
      );
   end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// ---------------------------------------------------------------------------
// tb_cdc_sync_filter
// Three configurations of cdc_sync_filter share one clock:
//   d0 : defaults (WIDTH=1, STAGES=2, FILTER_CYCLES=1, RESET_VAL=0)
//   d1 : WIDTH=4, STAGES=3, FILTER_CYCLES=4
//   d2 : WIDTH=2, STAGES=2, FILTER_CYCLES=1, RESET_VAL=1
// The reference model treats each channel as "input delayed by STAGES edges"
// and accepts a new level when the last FILTER_CYCLES delayed samples all
// differ from the accepted level.
// ---------------------------------------------------------------------------
module tb_cdc_sync_filter;

   logic sysClk = 1'b0;
   always #5 sysClk = ~sysClk;

   logic [2:0] rn = 3'b111;
   logic [3:0] a_in [3];
   logic [3:0] clr  [3];
   logic [3:0] sy [3], ri [3], fa [3], ef [3];

   logic [0:0] s0, r0, f0, e0;
   logic [3:0] s1, r1, f1, e1;
   logic [1:0] s2, r2, f2, e2;

   cdc_sync_filter u_d0 (
      .sysClk_i (sysClk), .reset_ni (rn[0]),
      .async_i (a_in[0][0:0]), .clear_i (clr[0][0:0]),
      .sync_o (s0), .rising_o (r0), .falling_o (f0), .edge_flag_o (e0)
   );

   cdc_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) u_d1 (
      .sysClk_i (sysClk), .reset_ni (rn[1]),
      .async_i (a_in[1]), .clear_i (clr[1]),
      .sync_o (s1), .rising_o (r1), .falling_o (f1), .edge_flag_o (e1)
   );

   cdc_sync_filter #(.WIDTH(2), .STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(1'b1)) u_d2 (
      .sysClk_i (sysClk), .reset_ni (rn[2]),
      .async_i (a_in[2][1:0]), .clear_i (clr[2][1:0]),
      .sync_o (s2), .rising_o (r2), .falling_o (f2), .edge_flag_o (e2)
   );

   assign sy[0] = {3'b000, s0};
   assign ri[0] = {3'b000, r0};
   assign fa[0] = {3'b000, f0};
   assign ef[0] = {3'b000, e0};
   assign sy[1] = s1;
   assign ri[1] = r1;
   assign fa[1] = f1;
   assign ef[1] = e1;
   assign sy[2] = {2'b00, s2};
   assign ri[2] = {2'b00, r2};
   assign fa[2] = {2'b00, f2};
   assign ef[2] = {2'b00, e2};

   // ---------------- reference model ----------------
   int stg [3] = '{2, 3, 2};
   int fcy [3] = '{1, 4, 1};
   int wd  [3] = '{1, 4, 2};
   bit rv  [3] = '{1'b0, 1'b0, 1'b1};

   bit inq [12][$];
   bit rh  [12][$];
   bit st  [12];
   logic [3:0] ex_sy [3], ex_ri [3], ex_fa [3], ex_ef [3];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic model_init(input int d);
      int k;
      for (int c = 0; c < 4; c++) begin
         k = d * 4 + c;
         inq[k].delete();
         rh[k].delete();
         for (int i = 0; i < stg[d]; i++) inq[k].push_back(rv[d]);
         for (int i = 0; i < fcy[d]; i++) rh[k].push_back(rv[d]);
         st[k] = rv[d];
      end
      ex_sy[d] = '0;
      ex_ri[d] = '0;
      ex_fa[d] = '0;
      ex_ef[d] = '0;
      for (int c = 0; c < wd[d]; c++) ex_sy[d][c] = rv[d];
   endtask

   task automatic model_edge(input int d);
      int k;
      bit raw;
      bit acc;
      for (int c = 0; c < wd[d]; c++) begin
         k = d * 4 + c;
         raw = inq[k].pop_front();
         inq[k].push_back(a_in[d][c]);
         void'(rh[k].pop_front());
         rh[k].push_back(raw);
         acc = 1'b1;
         for (int i = 0; i < rh[k].size(); i++) begin
            if (rh[k][i] == st[k]) acc = 1'b0;
         end
         ex_ri[d][c] = acc & raw;
         ex_fa[d][c] = acc & ~raw;
         if (acc) begin
            st[k] = raw;
            ex_ef[d][c] = 1'b1;
         end else if (clr[d][c]) begin
            ex_ef[d][c] = 1'b0;
         end
         ex_sy[d][c] = st[k];
      end
   endtask

   // One clock edge; returns at the following falling edge for sampling.
   task automatic step();
      @(posedge sysClk);
      for (int d = 0; d < 3; d++) begin
         if (rn[d]) model_edge(d);
         else       model_init(d);
      end
      @(negedge sysClk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [3:0] rs [3];
      rs = '{4'b0000, 4'b0000, 4'b0011};
      a_in[0] = 4'b0000; a_in[1] = 4'b0000; a_in[2] = 4'b0011;
      clr[0]  = 4'b0000; clr[1]  = 4'b0000; clr[2]  = 4'b0000;
      #1 rn = 3'b000;
      for (int d = 0; d < 3; d++) model_init(d);
      repeat (3) step();
      for (int d = 0; d < 3; d++) begin
         n_tests++;
         if (sy[d] !== rs[d]) begin n_fail++; $display("FAIL reset_sync d%0d: got %b expected %b", d, sy[d], rs[d]); end
         n_tests++;
         if ((ri[d] | fa[d] | ef[d]) !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pulse_flag d%0d: got r=%b f=%b e=%b expected all 0", d, ri[d], fa[d], ef[d]);
         end
      end
      rn = 3'b111;
   endtask

   task automatic test_reset_val1();
      logic [3:0] es, ef_exp;
      for (int e = 1; e <= 6; e++) begin
         step();
         n_tests++;
         if (sy[2] !== 4'b0011 || ri[2] !== 4'b0000 || fa[2] !== 4'b0000 || ef[2] !== 4'b0000) begin
            n_fail++; $display("FAIL rv1_quiet e=%0d: got s=%b r=%b f=%b e=%b expected s=0011 others 0", e, sy[2], ri[2], fa[2], ef[2]);
         end
      end
      a_in[2][1] = 1'b0;
      for (int e = 1; e <= 5; e++) begin
         step();
         es     = (e >= 3) ? 4'b0001 : 4'b0011;
         ef_exp = (e == 3) ? 4'b0010 : 4'b0000;
         n_tests++;
         if (sy[2] !== es) begin n_fail++; $display("FAIL rv1_sync e=%0d: got %b expected %b", e, sy[2], es); end
         n_tests++;
         if (fa[2] !== ef_exp || ri[2] !== 4'b0000) begin
            n_fail++; $display("FAIL rv1_fall e=%0d: got f=%b r=%b expected f=%b r=0000", e, fa[2], ri[2], ef_exp);
         end
      end
   endtask

   task automatic test_default_latency();
      logic x_s, x_r;
      a_in[0][0] = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         step();
         x_s = (e >= 3);
         x_r = (e == 3);
         n_tests++;
         if (s0 !== x_s) begin n_fail++; $display("FAIL dflt_sync e=%0d: got %b expected %b", e, s0, x_s); end
         n_tests++;
         if (r0 !== x_r || f0 !== 1'b0) begin n_fail++; $display("FAIL dflt_pulse e=%0d: got r=%b f=%b expected r=%b f=0", e, r0, f0, x_r); end
         n_tests++;
         if (e0 !== x_s) begin n_fail++; $display("FAIL dflt_flag e=%0d: got %b expected %b", e, e0, x_s); end
      end
   endtask

   task automatic test_glitch();
      logic [3:0] xs, xr, xf;
      for (int e = 1; e <= 16; e++) begin
         a_in[1][2] = (e <= 3);
         step();
         n_tests++;
         if (sy[1] !== 4'b0000 || ri[1] !== 4'b0000 || ef[1] !== 4'b0000) begin
            n_fail++; $display("FAIL glitch_short e=%0d: got s=%b r=%b e=%b expected all 0", e, sy[1], ri[1], ef[1]);
         end
      end
      for (int e = 1; e <= 14; e++) begin
         a_in[1][2] = (e <= 4);
         step();
         xs = (e >= 7 && e <= 10) ? 4'b0100 : 4'b0000;
         xr = (e == 7)  ? 4'b0100 : 4'b0000;
         xf = (e == 11) ? 4'b0100 : 4'b0000;
         n_tests++;
         if (sy[1] !== xs) begin n_fail++; $display("FAIL glitch_exact_sync e=%0d: got %b expected %b", e, sy[1], xs); end
         n_tests++;
         if (ri[1] !== xr || fa[1] !== xf) begin
            n_fail++; $display("FAIL glitch_exact_pulse e=%0d: got r=%b f=%b expected r=%b f=%b", e, ri[1], fa[1], xr, xf);
         end
      end
   endtask

   task automatic test_bounce();
      bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] xs, xr;
      for (int e = 1; e <= 13; e++) begin
         a_in[1][0] = (e <= 7) ? pat[e-1] : 1'b1;
         step();
         xs = (e >= 10) ? 4'b0001 : 4'b0000;
         xr = (e == 10) ? 4'b0001 : 4'b0000;
         n_tests++;
         if (sy[1] !== xs || ri[1] !== xr) begin
            n_fail++; $display("FAIL bounce e=%0d: got s=%b r=%b expected s=%b r=%b", e, sy[1], ri[1], xs, xr);
         end
      end
      a_in[1][0] = 1'b0;
      repeat (9) step();
   endtask

   task automatic test_set_clear();
      clr[0][0] = 1'b1;
      step();
      clr[0][0] = 1'b0;
      n_tests++;
      if (e0 !== 1'b0) begin n_fail++; $display("FAIL clear_plain: got %b expected 0", e0); end
      a_in[0][0] = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         clr[0][0] = (e >= 3);
         step();
         if (e == 3) begin
            n_tests++;
            if (f0 !== 1'b1 || e0 !== 1'b1) begin n_fail++; $display("FAIL set_wins: got f=%b e=%b expected f=1 e=1", f0, e0); end
         end
         if (e == 4) begin
            n_tests++;
            if (f0 !== 1'b0 || e0 !== 1'b0) begin n_fail++; $display("FAIL clear_after: got f=%b e=%b expected f=0 e=0", f0, e0); end
         end
      end
      clr[0][0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] xs, xr;
      a_in[1][1] = 1'b1;
      repeat (5) step();
      n_tests++;
      if (sy[1][1] !== 1'b0) begin n_fail++; $display("FAIL mid_prefilter: got %b expected 0", sy[1][1]); end
      #2 rn[1] = 1'b0;
      model_init(1);
      #1;
      n_tests++;
      if (sy[1] !== 4'b0000 || ri[1] !== 4'b0000 || fa[1] !== 4'b0000 || ef[1] !== 4'b0000) begin
         n_fail++; $display("FAIL mid_async_reset: got s=%b r=%b f=%b e=%b expected all 0", sy[1], ri[1], fa[1], ef[1]);
      end
      @(negedge sysClk);
      step();
      rn[1] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         xs = (e >= 7) ? 4'b0010 : 4'b0000;
         xr = (e == 7) ? 4'b0010 : 4'b0000;
         n_tests++;
         if (sy[1] !== xs || ri[1] !== xr) begin
            n_fail++; $display("FAIL mid_refilter e=%0d: got s=%b r=%b expected s=%b r=%b", e, sy[1], ri[1], xs, xr);
         end
      end
      a_in[1][1] = 1'b0;
      repeat (9) step();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < wd[d]; c++) begin
               if ($urandom_range(0, 5) == 0) a_in[d][c] = ~a_in[d][c];
               clr[d][c] = ($urandom_range(0, 3) == 0);
            end
         end
         step();
         for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (sy[d] !== ex_sy[d]) begin n_fail++; $display("FAIL rand_sync n=%0d d%0d: got %b expected %b", n, d, sy[d], ex_sy[d]); end
            n_tests++;
            if (ri[d] !== ex_ri[d]) begin n_fail++; $display("FAIL rand_rise n=%0d d%0d: got %b expected %b", n, d, ri[d], ex_ri[d]); end
            n_tests++;
            if (fa[d] !== ex_fa[d]) begin n_fail++; $display("FAIL rand_fall n=%0d d%0d: got %b expected %b", n, d, fa[d], ex_fa[d]); end
            n_tests++;
            if (ef[d] !== ex_ef[d]) begin n_fail++; $display("FAIL rand_flag n=%0d d%0d: got %b expected %b", n, d, ef[d], ex_ef[d]); end
            n_tests++;
            if ((ri[d] & fa[d]) !== 4'b0000) begin n_fail++; $display("FAIL rand_exclusive n=%0d d%0d: got %b expected 0000", n, d, ri[d] & fa[d]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_val1();
      test_default_latency();
      test_glitch();
      test_bounce();
      test_set_clear();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

endmodule

// File: doc/cdc_sync_filter.md
Name: cdc_sync_filter

Overview:
- Parametrised multi-channel successor to the 2-FF + edge-detect synchroniser.
- Brings WIDTH independent asynchronous single-bit signals into the sysClk_i domain through a synchroniser chain of configurable depth.
- Optionally debounces each channel with a stable-for-N-cycles filter.
- Emits registered per-channel rising/falling pulses and sticky edge flags with software clear.
- Used for buttons, external strobes and slow control lines feeding the SPI and CPU blocks.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser flops per channel, minimum 2 (elaboration error below 2).
- FILTER_CYCLES, 1: consecutive cycles the synchronised value must differ from the filtered state before it is accepted. 1 = no filtering. Minimum 1.
- RESET_VAL, 0: 1-bit value loaded into every sync flop and filtered state at reset.

Ports:
- sysClk_i  input  1  destination clock; all logic on posedge.
- reset_ni  input  1  asynchronous, active-low reset.
- async_i  input  WIDTH  asynchronous inputs; one bit per channel.
- clear_i  input  WIDTH  synchronous per-channel clear of edge_flag_o.
- sync_o  output  WIDTH  filtered, synchronised level (registered).
- rising_o  output  WIDTH  one-cycle pulse when sync_o goes 0->1 (registered).
- falling_o  output  WIDTH  one-cycle pulse when sync_o goes 1->0 (registered).
- edge_flag_o  output  WIDTH  sticky flag, set by either edge pulse.

Behaviour:
- Reset (reset_ni low, asynchronous):
  - s[0..STAGES-1] = RESET_VAL; state = RESET_VAL; cnt = 0.
  - rising_o = falling_o = 0; edge_flag_o = 0.
  - sync_o = RESET_VAL.
  - Reset asserted mid-filter discards any partial count.
- Sync chain, per channel, each edge: s[0] <= async_i; s[i] <= s[i-1]. raw = s[STAGES-1]. No logic between chain flops.
- Filter, per channel, counter cnt of width $clog2(FILTER_CYCLES+1), each edge:
  - raw == state: cnt <= 0; no pulse.
  - raw != state and cnt == FILTER_CYCLES-1: state <= raw; cnt <= 0; pulse in that direction.
  - Otherwise: cnt <= cnt+1.
  - cnt never exceeds FILTER_CYCLES-1, so no wrap.
- Pulses:
  - rising_o is 1 exactly in the cycle after the edge where state goes 0->1; falling_o likewise for 1->0. Both are otherwise 0.
  - A pulse is coincident with the new sync_o value.
  - rising_o and falling_o are never both 1 on one channel.
- Latency: an input change first captured at edge 1 appears on sync_o and the pulse at edge STAGES+FILTER_CYCLES. With defaults (STAGES=2, FILTER_CYCLES=1) this is edge 3.
- Glitch rejection: a raw excursion shorter than FILTER_CYCLES cycles produces no sync_o change and no pulse, and cnt returns to 0. An excursion of exactly FILTER_CYCLES cycles is accepted.
- Minimum pulse spacing: consecutive opposite pulses on a channel are at least FILTER_CYCLES cycles apart.
- edge_flag_o[i]:
  - Set on the edge where the rising or falling pulse is generated.
  - Cleared on an edge with clear_i[i]=1.
  - Set and clear on the same edge: set wins.
  - Holds otherwise.
- After reset release with async_i != RESET_VAL, a normal edge pulse occurs after the standard latency. This is intended.
- Channels are fully independent; no cross-channel skew guarantee. The block does not make a multi-bit bus coherent.

Decomposition:
- Package cdc_pkg:
  - CDC_MIN_STAGES = 2.
  - Function cdc_cnt_width(FILTER_CYCLES) returning $clog2(FILTER_CYCLES+1), min 1.
- Sub-module cdc_sync_channel holds one channel: chain, filter counter, state, pulse regs and sticky flag.
- Top cdc_sync_filter instantiates WIDTH copies in a generate loop and checks parameter legality.

Test Plan:
- Reset, defaults: async_i=0 held, toggle reset_ni -> all outputs 0. Raise async_i=1 just before edge 1 -> sync_o=1 and rising_o=1 for one cycle at edge 3; edge_flag_o=1 stays.
- WIDTH=4, STAGES=3, FILTER_CYCLES=4: drive async_i[2]=1 for 3 cycles then 0 -> no change on sync_o, rising_o or edge_flag_o for any channel. Drive it 1 for 4 cycles -> sync_o[2]=1 and rising_o[2] pulse at edge 7 after capture; others stay 0.
- Same config, bounce raw 1,1,0,1,1,1,1 -> cnt restarts after the 0. Pulse fires 4 cycles after the last restart, never earlier.
- Set and clear same edge: a pulse on channel 0 coincides with clear_i[0]=1 -> edge_flag_o[0]=1. clear_i[0]=1 on the next edge -> 0.
- RESET_VAL=1, async_i=1 through reset -> no pulse after release. Then async_i=0 -> falling_o pulse at the standard latency.
- Reset mid-filter: assert reset_ni at cnt=2 of 4 -> outputs return to reset values immediately (asynchronously). After release, a full FILTER_CYCLES is required again.
